// File: rtl/lsu_pkg.sv
// Shared types for the load/store data-memory controller: FSM states,
// RV32I funct3 codes and the load-lane extension helper.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // raw already has the selected lane shifted down to bit 0
  function automatic logic [31:0] lsu_extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{raw[7]}}, raw[7:0]};
      F3_H:    return {{16{raw[15]}}, raw[15:0]};
      F3_BU:   return {24'h0, raw[7:0]};
      F3_HU:   return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: merges store bytes/halves into a read word
// and extracts + extends the addressed lane for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  always_comb begin
    st_word = rd_word;
    case (funct3[1:0])
      2'b00:   st_word[{off, 3'b000} +: 8]      = st_data[7:0];
      2'b01:   st_word[{off[1], 4'b0000} +: 16] = st_data[15:0];
      default: st_word = st_data;
    endcase
  end

  assign ld_data = lsu_extend(rd_word >> {off, 3'b000}, funct3);

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store initiator for a word-wide, combinational-read data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wr_en,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              illegal, trap;
  logic [ADDR_W-1:0] addr_al;
  logic [31:0]       idx, st_word, ld_data;

  always_comb begin
    illegal = req_we ? (req_funct3 > F3_W)
                     : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    addr_al = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
           (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    trap = 1'b0;
    if (req_funct3[1:0] == 2'b01) addr_al[0]   = 1'b0;
    if (req_funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
`endif
    idx = 32'((addr_al >> 2) % ADDR_W'(MEM_WORDS));
  end

  lsu_lane_align u_align (
    .rd_word (mem_rdata),
    .st_data (wdata_q),
    .funct3  (f3_q),
    .off     (off_q),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b0;
      off_q        <= 2'b0;
      wdata_q      <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wr_en_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_en_q  <= mem_wr_en_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (illegal || trap)              state_d = RESP;
        else if (req_we && req_funct3 == F3_W) state_d = WR;
        else                              state_d = RD;
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded with the value they must show in state_d
  always_comb begin
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_en_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        off_d   = addr_al[1:0];
        wdata_d = req_wdata;
        if (state_d == RESP) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          mem_addr_d = idx;
          if (state_d == WR) begin
            mem_wr_en_d = 1'b1;
            mem_wdata_d = req_wdata;
          end
        end
      end
      RD: if (we_q) begin
        mem_wr_en_d = 1'b1;
        mem_wdata_d = st_word;
      end else begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      WR:      resp_valid_d = 1'b1;
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: directed vector table, reset-abort sequence and
// random traffic against a byte-addressed reference model.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_err, mem_wr_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  lsu_dmem_ctrl #(.ADDR_W(32), .MEM_WORDS(2048)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic [7:0]  ref_b [0:8191];
  assign mem_rdata = mem[mem_addr[10:0]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[10:0]] <= mem_wdata;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
  endfunction

  // Byte-level model: legality, alignment, latency, memory effect, load result
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output int lat,
                       output logic [31:0] rd, output int nwr, output int widx);
    int n, base;
    logic [31:0] aa;
    logic legal;
    err = 1'b0; rd = 32'h0; nwr = 0; widx = 0; lat = 0;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (!legal) begin err = 1'b1; lat = 1; return; end
    aa = a - (a % n);
`ifdef LSU_MISALIGN_TRAP_EN
    if (aa != a) begin err = 1'b1; lat = 1; return; end
`endif
    widx = int'((aa >> 2) % 2048);
    base = widx * 4 + int'(aa[1:0]);
    if (we) begin
      for (int i = 0; i < n; i++) ref_b[base+i] = wd[8*i +: 8];
      nwr = 1;
      lat = (n == 4) ? 2 : 3;
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(ref_b[base+i]) << (8*i));
      if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
      lat = 2;
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err, output int nwr, output logic [31:0] waddr,
                         output int wcyc);
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("resp_single_pulse", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rd = 32'h0; err = 1'b0; nwr = 0; waddr = 32'h0; wcyc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_wr_en) begin nwr++; waddr = mem_addr; wcyc = k; end
      if (resp_valid) begin lat = k; rd = resp_rdata; err = resp_err; break; end
    end
  endtask

  // Runs one request, checks memory-side behaviour against the model
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic err, output logic m_err, output int m_lat,
                     output logic [31:0] m_rd);
    int m_nwr, m_widx, nwr, wcyc;
    logic [31:0] waddr;
    model(we, f3, a, wd, m_err, m_lat, m_rd, m_nwr, m_widx);
    run_req(we, f3, a, wd, lat, rd, err, nwr, waddr, wcyc);
    chk("wr_count", 32'(nwr), 32'(m_nwr));
    if (m_nwr == 1) begin
      chk("wr_addr", waddr, 32'(m_widx));
      chk("wr_cycle", 32'(wcyc), 32'(m_lat - 1));
      chk("mem_word", mem[m_widx], ref_word(m_widx));
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl [0:16];

  function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] er,
                               input logic ee, input int el);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  initial begin
    int lat, m_lat, busy;
    logic [31:0] rd, m_rd;
    logic err, m_err;

    for (int w = 0; w < 2048; w++) begin
      logic [31:0] r;
      r = $urandom;
      mem[w] = r;
      for (int b = 0; b < 4; b++) ref_b[w*4+b] = r[8*b +: 8];
    end

    tbl[0]  = mkv(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2);
    tbl[1]  = mkv(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2);
    tbl[2]  = mkv(1, 3'b010, 32'h10,   32'h11223344, 32'h0,        0, 2);
    tbl[3]  = mkv(1, 3'b000, 32'h13,   32'h0000005A, 32'h0,        0, 3);
    tbl[4]  = mkv(0, 3'b010, 32'h10,   32'h0,        32'h5A223344, 0, 2);
    tbl[5]  = mkv(1, 3'b010, 32'h20,   32'h80FF7F01, 32'h0,        0, 2);
    tbl[6]  = mkv(0, 3'b000, 32'h22,   32'h0,        32'hFFFFFFFF, 0, 2);
    tbl[7]  = mkv(0, 3'b100, 32'h22,   32'h0,        32'h000000FF, 0, 2);
    tbl[8]  = mkv(0, 3'b001, 32'h22,   32'h0,        32'hFFFF80FF, 0, 2);
    tbl[9]  = mkv(0, 3'b101, 32'h20,   32'h0,        32'h00007F01, 0, 2);
    tbl[10] = mkv(0, 3'b011, 32'h20,   32'h0,        32'h0,        1, 1);
    tbl[11] = mkv(1, 3'b111, 32'h20,   32'h12345678, 32'h0,        1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[12] = mkv(0, 3'b010, 32'h21,   32'h0,        32'h0,        1, 1);
`else
    tbl[12] = mkv(0, 3'b010, 32'h21,   32'h0,        32'h80FF7F01, 0, 2);
`endif
    tbl[13] = mkv(1, 3'b010, 32'h2000, 32'hCAFEF00D, 32'h0,        0, 2);
    tbl[14] = mkv(0, 3'b010, 32'h0,    32'h0,        32'hCAFEF00D, 0, 2);
    tbl[15] = mkv(1, 3'b001, 32'h22,   32'h1234ABCD, 32'h0,        0, 3);
    tbl[16] = mkv(0, 3'b010, 32'h20,   32'h0,        32'hABCD7F01, 0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {28'b0, resp_valid, resp_err, mem_wr_en, req_ready}, 32'h1);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, rd, err, m_err, m_lat, m_rd);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
    end

    // Reset while an SB sits in WR: the strobed write lands, no response follows
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h41; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wr_en", {31'b0, mem_wr_en}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_flags", {28'b0, resp_valid, resp_err, mem_wr_en, req_ready}, 32'h1);
    chk("abort_rdata", resp_rdata, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    busy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) busy++;
    end
    chk("abort_no_resp", 32'(busy), 32'd0);
    begin
      int d_lat, d_nwr, d_widx;
      logic d_err;
      logic [31:0] d_rd;
      model(1'b1, 3'b000, 32'h41, 32'h77, d_err, d_lat, d_rd, d_nwr, d_widx);
      chk("abort_write_kept", mem[16], ref_word(16));
    end

    for (int t = 0; t < 300; t++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FFF));
      txn(we, f3, a, $urandom, lat, rd, err, m_err, m_lat, m_rd);
      chk("rnd_rdata", rd, m_rd);
      chk("rnd_err", {31'b0, err}, {31'b0, m_err});
      chk("rnd_lat", 32'(lat), 32'(m_lat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store initiator between the RV32I execute stage and the word-wide data memory.
- Memory side: combinational read, single word write-enable, word-indexed address.
- Accepts one byte, halfword or word load/store at a time from the core. Sub-word stores run as read-modify-write.
- Loads return sign- or zero-extended data through a one-cycle response pulse.

Parameters:
- ADDR_W, 32, core byte-address width
- MEM_WORDS, 2048, data memory depth in words; the word index wraps modulo MEM_WORDS

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; the low byte/half is used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  illegal funct3 (or misaligned, see the optional feature)
- mem_wr_en  out  1  word write strobe to the data memory
- mem_addr  out  32  word index, zero-extended: (req_addr >> 2) mod MEM_WORDS
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Reset: synchronous, active-low, sampled on the posedge of clk. It forces state IDLE and clears every output register: req_ready=1 in IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the access. A write already strobed stays in memory; no response is issued.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/funct3/addr/wdata.
  - Load, or SB/SH -> RD. SW -> WR.
  - Illegal funct3 -> RESP with err=1, no memory access. Illegal codes: load 011/110/111; store anything other than 000/001/010.
- RD:
  - Drive mem_addr from the captured address and register mem_rdata.
  - Load -> RESP. Sub-word store -> WR.
- WR:
  - mem_wr_en=1 for exactly this cycle.
  - mem_wdata = the full word for SW.
  - For SB/SH: the registered word with lane addr[1:0] (byte) or addr[1] (half) replaced.
  - Next state -> RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - Load data: lane selected by addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Next state -> IDLE. req_ready=0 in RD/WR/RESP.
- Latency from the accept cycle T to resp_valid:
  - LW/LB/LH/LBU/LHU: T+2
  - SW: T+2
  - SB/SH: T+3
- Throughput: at most one request in flight. A new request is accepted no earlier than the cycle after RESP.
- Address wrap: byte address 4*MEM_WORDS maps to word 0.
- Request signals are ignored when req_valid=0 and outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) go from IDLE to RESP with resp_err=1.
  - No memory read or write.
  - Latency is T+1.
- Undefined:
  - Misaligned requests are forced to natural alignment: addr[0] is cleared for halfwords; addr[1:0] is cleared for words.
  - The request then proceeds normally with resp_err=0.

Decomposition:
- Shared package lsu_pkg:
  - state enum lsu_state_e (IDLE, RD, WR, RESP)
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - function for extending the loaded lane
- One sub-module, lsu_lane_align: a purely combinational block that merges store lanes and extracts load lanes. The FSM stays in the top module.

Test Plan:
- Reset mid-SB: reset driven during WR -> outputs all 0 and state IDLE next cycle; no resp_valid.
- SW to addr 0x10 with data 0xDEADBEEF, then LW from 0x10:
  - mem_wr_en high for one cycle with mem_addr=4
  - load resp_rdata=0xDEADBEEF at T+2
- SB data 0x5A to addr 0x13 over the word 0x11223344:
  - read, then write of 0x5A223344 at T+2
  - resp_valid at T+3
- Word at 0x20 = 0x80FF7F01:
  - LB 0x22 -> 0xFFFFFFFF; LBU 0x22 -> 0x000000FF
  - LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01
- Illegal load funct3 011 -> resp_err=1 and resp_valid at T+1; mem_wr_en never high.
- LW from 0x21:
  - with LSU_MISALIGN_TRAP_EN -> err=1 at T+1, no memory read
  - without the macro -> data of word 0x20 at T+2, err=0
  - byte address 0x2000 (MEM_WORDS=2048) -> mem_addr=0
